// File: rtl/disp_pkg.sv
// Shared constants and the active-low one-hot anode helper for the display scan mux.
package disp_pkg;

    localparam int DIGIT_W_DEF  = 4;
    localparam int N_DIGITS_MIN = 2;
    localparam int N_DIGITS_MAX = 16;
    localparam int IDX_W_MAX    = $clog2(N_DIGITS_MAX);

    // Callers size-cast the result down to their own digit count.
    function automatic logic [N_DIGITS_MAX-1:0] anode_onehot_n(input logic [IDX_W_MAX-1:0] idx);
        logic [N_DIGITS_MAX-1:0] r;
        r      = '1;
        r[idx] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Digit-slot prescaler: counts enabled cycles and pulses tick on the last count of each slot.
module tick_gen #(
    parameter int PRESCALE = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Gating with en means a slot never advances on a cycle where scanning is paused.
    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/display_scan_mux.sv
// Multiplexed N-digit display scanner with frame-synchronous shadow capture.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_mux
    import disp_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int DIGIT_W  = DIGIT_W_DEF,
    parameter int PRESCALE = 100000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [N_DIGITS*DIGIT_W-1:0] digits_in,
    input  logic [N_DIGITS-1:0]         dp_in,
    output logic [DIGIT_W-1:0]          digit_out,
    output logic [N_DIGITS-1:0]         anode_n,
    output logic                        dp_out,
    output logic [$clog2(N_DIGITS)-1:0] sel_idx,
    output logic                        frame_start
);

    localparam int SW = $clog2(N_DIGITS);

    logic               tick, wrap, blank;
    logic [SW-1:0]      sel_q, sel_d;
    logic [DIGIT_W-1:0] sh_q [N_DIGITS];
    logic [N_DIGITS-1:0] shdp_q;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               dp_q, dp_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic               frame_q;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    assign wrap  = tick && (sel_q == SW'(N_DIGITS - 1));
    assign sel_d = tick ? (wrap ? '0 : sel_q + 1'b1) : sel_q;

`ifdef LEADING_ZERO_BLANK_EN
    // Highest digit that must stay lit: last non-zero code or last requested decimal point.
    logic [SW-1:0] keep_lim;
    always_comb begin
        keep_lim = '0;
        for (int k = 0; k < N_DIGITS; k++)
            if (sh_q[k] != '0 || shdp_q[k]) keep_lim = SW'(k);
    end
    assign blank = sel_q > keep_lim;
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        digit_d = digit_q;
        dp_d    = dp_q;
        an_d    = '1;
        if (en) begin
            digit_d = sh_q[sel_q];
            dp_d    = shdp_q[sel_q];
            if (!blank) an_d = N_DIGITS'(anode_onehot_n(IDX_W_MAX'(sel_q)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            digit_q <= '0;
            dp_q    <= 1'b0;
            an_q    <= '1;
            frame_q <= 1'b0;
            shdp_q  <= '0;
            for (int k = 0; k < N_DIGITS; k++) sh_q[k] <= '0;
        end else begin
            sel_q   <= sel_d;
            digit_q <= digit_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= wrap;
            if (wrap) begin
                shdp_q <= dp_in;
                for (int k = 0; k < N_DIGITS; k++) sh_q[k] <= digits_in[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign sel_idx     = sel_q;
    assign digit_out   = digit_q;
    assign dp_out      = dp_q;
    assign anode_n     = an_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: two instances (4 digits / prescale 4, 2 digits / prescale 1) against a count-based model.
module tb_display_scan_mux;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        en, en2;
    logic [15:0] din;
    logic [3:0]  dpin;
    logic [7:0]  din2;
    logic [1:0]  dp2;

    logic [3:0] dout, an;
    logic       dpo, fs;
    logic [1:0] sel;
    logic [3:0] dout2;
    logic [1:0] an2;
    logic       dpo2, fs2;
    logic       sel2;

    display_scan_mux #(.N_DIGITS(4), .DIGIT_W(4), .PRESCALE(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_in(din), .dp_in(dpin),
        .digit_out(dout), .anode_n(an), .dp_out(dpo), .sel_idx(sel), .frame_start(fs)
    );

    display_scan_mux #(.N_DIGITS(2), .DIGIT_W(4), .PRESCALE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .digits_in(din2), .dp_in(dp2),
        .digit_out(dout2), .anode_n(an2), .dp_out(dpo2), .sel_idx(sel2), .frame_start(fs2)
    );

    int errors = 0;
    int checks = 0;

    // Model: everything follows from the number of enabled cycles since reset.
    int          mp[2] = '{4, 1};
    int          mn[2] = '{4, 2};
    int          cnt[2];
    logic [3:0]  sh[2][16];
    logic        shdp[2][16];
    logic [3:0]  m_dig[2];
    logic        m_dp[2];
    logic [15:0] m_an[2];
    logic        m_fs[2];

    function automatic int msel(input int i);
        return (cnt[i] / mp[i]) % mn[i];
    endfunction

    function automatic logic [15:0] all_off(input int i);
        return 16'((1 << mn[i]) - 1);
    endfunction

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0;
            for (int k = 0; k < 16; k++) begin
                sh[i][k]   = 4'h0;
                shdp[i][k] = 1'b0;
            end
            m_dig[i] = 4'h0;
            m_dp[i]  = 1'b0;
            m_an[i]  = all_off(i);
            m_fs[i]  = 1'b0;
        end
    endtask

    task automatic mstep(input int i, input logic e, input logic [15:0] d, input logic [15:0] dp);
        int s;
        s = msel(i);
        m_fs[i] = 1'b0;
        if (e) begin
            m_an[i] = all_off(i) & ~(16'(1) << s);
`ifdef LEADING_ZERO_BLANK_EN
            begin
                int lim;
                lim = 0;
                for (int k = 0; k < mn[i]; k++)
                    if (sh[i][k] != 4'h0 || shdp[i][k]) lim = k;
                if (s > lim) m_an[i] = all_off(i);
            end
`endif
            m_dig[i] = sh[i][s];
            m_dp[i]  = shdp[i][s];
            cnt[i]++;
            if (cnt[i] % (mp[i] * mn[i]) == 0) begin
                m_fs[i] = 1'b1;
                for (int k = 0; k < mn[i]; k++) begin
                    sh[i][k]   = d[k*4 +: 4];
                    shdp[i][k] = dp[k];
                end
            end
        end else begin
            m_an[i] = all_off(i);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic compare();
        chk("a.sel_idx",     16'(sel),   16'(msel(0)));
        chk("a.digit_out",   16'(dout),  16'(m_dig[0]));
        chk("a.dp_out",      16'(dpo),   16'(m_dp[0]));
        chk("a.anode_n",     16'(an),    m_an[0]);
        chk("a.frame_start", 16'(fs),    16'(m_fs[0]));
        chk("b.sel_idx",     16'(sel2),  16'(msel(1)));
        chk("b.digit_out",   16'(dout2), 16'(m_dig[1]));
        chk("b.dp_out",      16'(dpo2),  16'(m_dp[1]));
        chk("b.anode_n",     16'(an2),   m_an[1]);
        chk("b.frame_start", 16'(fs2),   16'(m_fs[1]));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) mreset();
        else begin
            mstep(0, en, din, {12'b0, dpin});
            mstep(1, en2, {8'b0, din2}, {14'b0, dp2});
        end
        #1 compare();
        en2  = ($urandom % 8) != 0;
        din2 = 8'($urandom);
        dp2  = 2'($urandom);
    endtask

    task automatic wait_slot(input int target, input int phase);
        int n;
        for (n = 0; n < 64 && !(msel(0) == target && cnt[0] % mp[0] == phase); n++) step();
        chk("wait_bound", 16'(n < 64), 16'(1));
    endtask

    task automatic chk_reset_vals();
        chk("rst.sel_idx",   16'(sel),  16'h0);
        chk("rst.digit_out", 16'(dout), 16'h0);
        chk("rst.dp_out",    16'(dpo),  16'h0);
        chk("rst.anode_n",   16'(an),   16'hf);
        chk("rst.frame",     16'(fs),   16'h0);
        chk("rst.b.anode_n", 16'(an2),  16'h3);
        chk("rst.b.sel_idx", 16'(sel2), 16'h0);
    endtask

    initial begin
        en = 1'b0; en2 = 1'b0; din = '0; dpin = '0; din2 = '0; dp2 = '0;
        #1 rst_n = 1'b0;
        #1 mreset();
        chk_reset_vals();
        compare();
        repeat (2) step();
        rst_n = 1'b1;

        // Basic scan; first frame shows zeros, second frame shows 1,2,3,4.
        en = 1'b1; din = 16'h4321; dpin = 4'h0;
        repeat (40) step();

        // Mid-frame change must wait for the next capture.
        wait_slot(2, 0);
        din = 16'h8765;
        repeat (40) step();

        // Pause in slot 1 for 10 cycles, then finish the slot.
        wait_slot(1, 2);
        en = 1'b0;
        repeat (10) step();
        chk("pause.sel_idx", 16'(sel), 16'h1);
        chk("pause.anode_n", 16'(an),  16'hf);
        en = 1'b1;
        repeat (20) step();

        // Enable drops exactly on the tick cycle.
        wait_slot(2, 3);
        en = 1'b0;
        repeat (2) step();
        en = 1'b1;
        repeat (12) step();

        // Blanking-relevant patterns (all digits lit in the default build).
        din = 16'h0050; dpin = 4'b0000;
        repeat (36) step();
        dpin = 4'b0100;
        repeat (36) step();

        repeat (300) begin
            en   = ($urandom % 6) != 0;
            din  = 16'($urandom);
            dpin = 4'($urandom);
            step();
        end

        // Asynchronous reset in the middle of a slot.
        en = 1'b1;
        repeat (6) step();
        rst_n = 1'b0;
        #1 chk_reset_vals();
        mreset();
        compare();
        #1 rst_n = 1'b1;
        din = 16'h4321; dpin = 4'h1;
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
